// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_port_arbiter: shares the single-port data RAM between the CPU MEM      |
// | stage (priority) and a peripheral master, with a starvation-forced stall.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dmem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_active,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       stall_count
);

  localparam int                 c_WAIT_W = 8;
  localparam logic [c_WAIT_W-1:0] c_LIMIT  = c_WAIT_W'(STARVE_LIMIT);
  localparam logic [c_WAIT_W-1:0] c_ONE    = c_WAIT_W'(1);
  localparam logic [15:0]         c_SAT    = 16'hFFFF;

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_rd_pend;
  logic [DATA_W-1:0]   r_p_rdata;
  logic [15:0]         r_stall_count;

  logic w_force;
  logic w_grant_p;

  // Every combinational output is qualified by reset so the RAM and both
  // masters see an all-zero interface while reset is held low.
  always_comb begin
    w_force   = reset & p_req & cpu_active & (r_wait_cnt == c_LIMIT);
    w_grant_p = reset & p_req & (~cpu_active | w_force);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (reset) begin
      if (w_grant_p) begin
        ram_we    = p_we;
        ram_addr  = p_addr;
        ram_wdata = p_wdata;
      end else begin
        ram_we    = cpu_we & cpu_active;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
    end
  end

  always_comb begin
    cpu_rdata   = reset ? ram_rdata : '0;
    cpu_stall   = w_force;
    p_gnt       = w_grant_p;
    p_rvalid    = r_rd_pend;
    // Response cycle shows live RAM data; the register holds it afterwards.
    p_rdata     = r_rd_pend ? ram_rdata : r_p_rdata;
    stall_count = r_stall_count;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (!p_req || w_grant_p) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_LIMIT) begin
      r_wait_cnt <= r_wait_cnt + c_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_pend <= 1'b0;
      r_p_rdata <= '0;
    end else begin
      r_rd_pend <= w_grant_p & ~p_we;
      if (r_rd_pend) begin
        r_p_rdata <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_force && (r_stall_count != c_SAT)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_port_arbiter: directed self-checking bench for dmem_port_arbiter.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clock;
  logic              reset;
  logic              cpu_active;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_rvalid;
  logic [DATA_W-1:0] p_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [15:0]       stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_active (cpu_active),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .p_req      (p_req),
    .p_we       (p_we),
    .p_addr     (p_addr),
    .p_wdata    (p_wdata),
    .p_gnt      (p_gnt),
    .p_rvalid   (p_rvalid),
    .p_rdata    (p_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM: read data appears one cycle after the address.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[12'h010] = 32'h0000_00AB;
    mem[12'h011] = 32'h0000_00CD;
    mem[12'h012] = 32'h0000_00EF;
    mem[12'h040] = 32'h5A5A_0040;
    ram_rdata    = '0;
    forever begin
      @(posedge clock);
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic drive_cpu(input logic act, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_active = act; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_p(input logic req, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    p_req = req; p_we = we; p_addr = a; p_wdata = d;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_p(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_cpu(1'b1, 1'b1, 12'h0AA, 32'h1111_2222);
    drive_p(1'b1, 1'b1, 12'h055, 32'h3333_4444);
    #2;
    n_cmp++;
    if ({p_gnt, cpu_stall, ram_we, p_rvalid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {p_gnt, cpu_stall, ram_we, p_rvalid});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata, p_rdata, cpu_rdata, stall_count} !== '0) begin
      n_bad++; $display("FAIL reset_buses: addr %h wdata %h prdata %h crdata %h cnt %h want all 0",
                        ram_addr, ram_wdata, p_rdata, cpu_rdata, stall_count);
    end
    apply_reset();
  endtask

  task automatic test_idle_read();
    apply_reset();
    @(negedge clock);
    drive_cpu(1'b0, 1'b0, 12'h000, '0);
    drive_p(1'b1, 1'b0, 12'h010, '0);
    #1;
    n_cmp++;
    if (p_gnt !== 1'b1 || cpu_stall !== 1'b0 || ram_addr !== 12'h010 || ram_we !== 1'b0) begin
      n_bad++; $display("FAIL idle_read_grant: gnt %b stall %b addr %h we %b want 1 0 010 0",
                        p_gnt, cpu_stall, ram_addr, ram_we);
    end
    @(negedge clock);
    drive_p(1'b0, 1'b0, '0, '0);
    #1;
    n_cmp++;
    if (p_rvalid !== 1'b1 || p_rdata !== 32'h0000_00AB) begin
      n_bad++; $display("FAIL idle_read_resp: rvalid %b rdata %h want 1 000000ab", p_rvalid, p_rdata);
    end
    n_cmp++;
    if (stall_count !== 16'd0 || cpu_stall !== 1'b0) begin
      n_bad++; $display("FAIL idle_read_nostall: cnt %0d stall %b want 0 0", stall_count, cpu_stall);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if (p_rvalid !== 1'b0 || p_rdata !== 32'h0000_00AB) begin
      n_bad++; $display("FAIL idle_read_hold: rvalid %b rdata %h want 0 000000ab", p_rvalid, p_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] datas [3];
    addrs[0] = 12'h010; addrs[1] = 12'h011; addrs[2] = 12'h012;
    datas[0] = 32'hAB;  datas[1] = 32'hCD;  datas[2] = 32'hEF;
    apply_reset();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clock);
      drive_cpu(1'b0, 1'b0, '0, '0);
      if (c < 3) drive_p(1'b1, 1'b0, addrs[c], '0);
      else       drive_p(1'b0, 1'b0, '0, '0);
      #1;
      if (c < 3) begin
        n_cmp++;
        if (p_gnt !== 1'b1) begin
          n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want 1", c, p_gnt);
        end
      end
      if (c > 0) begin
        n_cmp++;
        if (p_rvalid !== 1'b1 || p_rdata !== datas[c-1]) begin
          n_bad++; $display("FAIL b2b_resp[%0d]: rvalid %b rdata %h want 1 %h", c, p_rvalid, p_rdata, datas[c-1]);
        end
      end
    end
  endtask

  task automatic test_forced_write();
    apply_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      drive_cpu(1'b1, 1'b0, 12'h100, '0);
      drive_p(1'b1, 1'b1, 12'h020, 32'h0000_1234);
      #1;
      n_cmp++;
      if (c < 8) begin
        if (p_gnt !== 1'b0 || cpu_stall !== 1'b0 || ram_addr !== 12'h100) begin
          n_bad++; $display("FAIL force_wait[%0d]: gnt %b stall %b addr %h want 0 0 100", c, p_gnt, cpu_stall, ram_addr);
        end
      end else begin
        if (p_gnt !== 1'b1 || cpu_stall !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'h020) begin
          n_bad++; $display("FAIL force_grant: gnt %b stall %b we %b addr %h want 1 1 1 020",
                            p_gnt, cpu_stall, ram_we, ram_addr);
        end
      end
    end
    @(negedge clock);
    drive_cpu(1'b1, 1'b0, 12'h020, '0);
    drive_p(1'b0, 1'b0, '0, '0);
    #1;
    n_cmp++;
    if (cpu_stall !== 1'b0 || stall_count !== 16'd1 || ram_addr !== 12'h020) begin
      n_bad++; $display("FAIL force_after: stall %b cnt %0d addr %h want 0 1 020", cpu_stall, stall_count, ram_addr);
    end
    @(negedge clock);
    drive_cpu(1'b0, 1'b0, '0, '0);
    #1;
    n_cmp++;
    if (cpu_rdata !== 32'h0000_1234 || p_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL force_readback: rdata %h rvalid %b want 00001234 0", cpu_rdata, p_rvalid);
    end
  endtask

  task automatic test_starvation_period();
    logic prev_stall;
    prev_stall = 1'b0;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      drive_cpu(1'b1, 1'b0, 12'h200, '0);
      drive_p(1'b1, 1'b1, 12'h300, 32'hC0DE_0000 + c);
      #1;
      n_cmp++;
      if (cpu_stall !== ((c == 8) || (c == 17) || (c == 26))) begin
        n_bad++; $display("FAIL period_stall[%0d]: got %b want %b", c, cpu_stall, (c == 8) || (c == 17) || (c == 26));
      end
      n_cmp++;
      if (prev_stall && cpu_stall) begin
        n_bad++; $display("FAIL period_consec[%0d]: stall got 1 want 0 after a stall", c);
      end
      prev_stall = cpu_stall;
    end
    @(negedge clock);
    drive_p(1'b0, 1'b0, '0, '0);
    #1;
    n_cmp++;
    if (stall_count !== 16'd3) begin
      n_bad++; $display("FAIL period_count: got %0d want 3", stall_count);
    end
  endtask

  task automatic test_cpu_store();
    apply_reset();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      if (c == 2)      drive_cpu(1'b1, 1'b1, 12'h005, 32'hDEAD);
      else if (c < 9)  drive_cpu(1'b1, 1'b0, 12'h005, '0);
      else             drive_cpu(1'b1, 1'b0, 12'h005, '0);
      if (c <= 8) drive_p(1'b1, 1'b0, 12'h040, '0);
      else        drive_p(1'b0, 1'b0, '0, '0);
      #1;
      if (c == 2) begin
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 12'h005 || ram_wdata !== 32'hDEAD || p_gnt !== 1'b0) begin
          n_bad++; $display("FAIL store_issue: we %b addr %h wdata %h gnt %b want 1 005 0000dead 0",
                            ram_we, ram_addr, ram_wdata, p_gnt);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (p_gnt !== 1'b0) begin
          n_bad++; $display("FAIL store_wait7: gnt %b want 0", p_gnt);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (p_gnt !== 1'b1 || cpu_stall !== 1'b1 || ram_we !== 1'b0) begin
          n_bad++; $display("FAIL store_force: gnt %b stall %b we %b want 1 1 0", p_gnt, cpu_stall, ram_we);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (p_rvalid !== 1'b1 || p_rdata !== 32'h5A5A_0040 || cpu_stall !== 1'b0) begin
          n_bad++; $display("FAIL store_presp: rvalid %b rdata %h stall %b want 1 5a5a0040 0",
                            p_rvalid, p_rdata, cpu_stall);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (cpu_rdata !== 32'h0000_DEAD) begin
          n_bad++; $display("FAIL store_readback: got %h want 0000dead", cpu_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      drive_cpu(1'b1, 1'b0, 12'h200, '0);
      drive_p(1'b1, 1'b1, 12'h300, 32'h77);
    end
    @(negedge clock);
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_p(1'b1, 1'b0, 12'h011, '0);
    #1;
    n_cmp++;
    if (p_gnt !== 1'b1 || stall_count !== 16'd1) begin
      n_bad++; $display("FAIL rstmid_pre: gnt %b cnt %0d want 1 1", p_gnt, stall_count);
    end
    @(negedge clock);
    reset = 1'b0;
    drive_cpu(1'b1, 1'b1, 12'h7FF, 32'hFFFF_FFFF);
    #1;
    n_cmp++;
    if ({p_gnt, cpu_stall, ram_we, p_rvalid} !== 4'b0000 ||
        {ram_addr, ram_wdata, p_rdata, cpu_rdata, stall_count} !== '0) begin
      n_bad++; $display("FAIL rstmid_zero: gnt %b stall %b we %b rv %b addr %h wd %h prd %h crd %h cnt %0d want all 0",
                        p_gnt, cpu_stall, ram_we, p_rvalid, ram_addr, ram_wdata, p_rdata, cpu_rdata, stall_count);
    end
    @(negedge clock);
    reset = 1'b1;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_p(1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (p_rvalid !== 1'b0 || p_rdata !== '0 || stall_count !== 16'd0) begin
        n_bad++; $display("FAIL rstmid_after[%0d]: rvalid %b rdata %h cnt %0d want 0 0 0", c, p_rvalid, p_rdata, stall_count);
      end
    end
  endtask

  task automatic test_req_drop();
    apply_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      drive_cpu(1'b1, 1'b0, 12'h200, '0);
      drive_p(c < 5, 1'b1, 12'h301, 32'h99);
      #1;
      n_cmp++;
      if (p_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
        n_bad++; $display("FAIL drop_pre[%0d]: gnt %b stall %b want 0 0", c, p_gnt, cpu_stall);
      end
    end
    for (int r = 0; r <= 8; r++) begin
      @(negedge clock);
      drive_p(1'b1, 1'b1, 12'h301, 32'h99);
      #1;
      n_cmp++;
      if (p_gnt !== (r == 8)) begin
        n_bad++; $display("FAIL drop_regrant[%0d]: gnt %b want %b", r, p_gnt, r == 8);
      end
    end
    @(negedge clock);
    drive_p(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b0;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_p(1'b0, 1'b0, '0, '0);
    test_reset();
    test_idle_read();
    test_back_to_back();
    test_forced_write();
    test_starvation_period();
    test_cpu_store();
    test_reset_mid_read();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data RAM between the pipelined processor's memory stage and a second master (the score/display peripheral engine). The CPU has priority. The peripheral is served in idle CPU memory cycles. A starvation counter forces a one-cycle CPU stall so the peripheral is always served eventually. The block sits between processor (wren/address_dmem/data/q_dmem) and RAM (wEn/addr/dataIn/dataOut).

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 32, RAM data width
STARVE_LIMIT, 8, peripheral wait cycles before a forced CPU stall; legal range 1..255

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
cpu_active  in  1  processor MEM stage holds a load/store this cycle
cpu_we  in  1  processor store enable
cpu_addr  in  ADDR_W  processor data address
cpu_wdata  in  DATA_W  processor store data
cpu_rdata  out  DATA_W  load data to processor
cpu_stall  out  1  freeze processor pipeline this cycle
p_req  in  1  peripheral request; held high until granted
p_we  in  1  peripheral write (1) / read (0)
p_addr  in  ADDR_W  peripheral address
p_wdata  in  DATA_W  peripheral write data
p_gnt  out  1  one-cycle pulse: peripheral access issued to RAM this cycle
p_rvalid  out  1  peripheral read data valid
p_rdata  out  DATA_W  peripheral read data
ram_we  out  1  to RAM wEn
ram_addr  out  ADDR_W  to RAM addr
ram_wdata  out  DATA_W  to RAM dataIn
ram_rdata  in  DATA_W  from RAM dataOut; valid one cycle after address issued
stall_count  out  16  count of forced stalls; saturates at 0xFFFF

Behaviour:
- Reset (reset low, async): wait_cnt=0, rd_pend=0, p_rdata=0, stall_count=0. All outputs are 0 while reset is low. A pending read response is discarded and p_rvalid is not asserted after reset releases.
- Grant decision is combinational each cycle. grant_p = p_req & (~cpu_active | force). force = (wait_cnt == STARVE_LIMIT) & cpu_active.
- cpu_stall = force. It never asserts when p_req=0 or cpu_active=0.
- RAM mux when grant_p=1: ram_addr=p_addr, ram_wdata=p_wdata, ram_we=p_we.
- RAM mux otherwise: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we&cpu_active.
- CPU writes are never issued in a stalled cycle. The processor re-presents the same access next cycle.
- p_gnt = grant_p.
- cpu_rdata = ram_rdata, combinational passthrough. It is not meaningful in the cycle after a peripheral read.
- wait_cnt:
  - cleared on grant_p.
  - incremented when p_req & ~grant_p, saturating at STARVE_LIMIT.
  - cleared when p_req=0.
- Read response: rd_pend is set on a peripheral read grant (grant_p & ~p_we).
  - Cycle after grant: p_rvalid=1, p_rdata=ram_rdata. p_rdata is latched and held until the next peripheral read response.
  - p_rvalid is exactly one cycle wide. Peripheral writes produce no p_rvalid.
- Back-to-back: p_req may stay high after p_gnt to issue the next access. Each grant is independent.
  - In CPU idle cycles, one access is granted per cycle.
  - With the CPU continuously active, forced grants occur at most once every STARVE_LIMIT+1 cycles. The CPU gets at least STARVE_LIMIT of every STARVE_LIMIT+1 cycles.
- stall_count increments by 1 on every force cycle and saturates.
- Simultaneous force and peripheral read: in the following cycle p_rvalid=1 and cpu_stall=0 unless a new force condition is met. The processor repeats its stalled access, which sees correct RAM data.
- Latency:
  - Peripheral read, CPU idle: p_gnt in the request cycle, p_rvalid the next cycle.
  - Worst case: p_gnt at most STARVE_LIMIT cycles after p_req rises.

Test Plan:
- CPU idle; peripheral reads addr 0x010 (RAM holds 0x0000_00AB) -> p_gnt same cycle, p_rvalid next cycle with p_rdata=0x0000_00AB, cpu_stall=0, stall_count=0.
- cpu_active held 1; p_req rises at cycle 0 for write of 0x1234 to 0x020 (STARVE_LIMIT=8) -> cycles 0-7 CPU owns RAM. Cycle 8: cpu_stall=1, p_gnt=1, ram_we=1, ram_addr=0x020. stall_count=1. CPU read of 0x020 at cycle 9 returns 0x1234 at cycle 10.
- cpu_active=1 with p_req held high for 30 cycles -> forced grants at cycles 8, 17, 26; stall_count=3; cpu_stall never on two consecutive cycles.
- CPU store (cpu_we=1, 0x005, 0xDEAD) while CPU active and peripheral waiting below limit -> ram_we=1, ram_addr=0x005; no p_gnt; wait_cnt increments.
- Reset pulled low the cycle after a peripheral read grant -> p_rvalid stays 0 after release, all outputs 0, stall_count=0.
- p_req dropped at wait_cnt=5, raised again -> wait restarts from 0; forced grant 8 cycles after re-raise, not 3.
